// File: rtl/mpy_pkg.sv
// Shared constants for the multiplier result path: operand/product widths and
// serializer FSM state encodings.
package mpy_pkg;

    localparam int MPY_W  = 32;
    localparam int PROD_W = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

endpackage

// File: rtl/mpy_result_serializer_if.sv
// Product-in / word-out bus of the result serializer.
// Handshake: a word transfers on a rising CLK edge where word_valid=1 and
// word_ready=1; while word_valid=1 and word_ready=0 the serializer holds
// word_out, word_last and word_valid stable. prod_valid is a one-cycle strobe
// with no back-pressure.
interface mpy_result_serializer_if #(parameter int CNT_W = 16);
    import mpy_pkg::*;

    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic [MPY_W-1:0]  word_out;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;
    logic              fifo_full;
    logic              overflow;
    logic [CNT_W-1:0]  results_done;

    modport master (
        output prod_in, prod_valid, word_ready,
        input  word_out, word_valid, word_last, fifo_full, overflow, results_done
    );

    modport slave (
        input  prod_in, prod_valid, word_ready,
        output word_out, word_valid, word_last, fifo_full, overflow, results_done
    );

endinterface

// File: rtl/mpy_prod_fifo.sv
// Circular DEPTH x PROD_W product FIFO. The caller only asserts push when there
// is room (or a pop shares the edge) and only asserts pop when occupancy > 0.
module mpy_prod_fifo
    import mpy_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [PROD_W-1:0]       din_i,
    output logic [PROD_W-1:0]       head_o,
    output logic [$clog2(DEPTH):0]  occ_o,
    output logic                    full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [PROD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       occ_q;

    always_ff @(posedge CLK) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_i && !pop_i) begin
                occ_q <= occ_q + (AW+1)'(1);
            end else if (pop_i && !push_i) begin
                occ_q <= occ_q - (AW+1)'(1);
            end
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;
    assign full_o = (occ_q == FULL_CNT);

endmodule

// File: rtl/mpy_result_serializer.sv
// Buffers 64-bit products from the Booth multiplier and serializes each one as
// a low then high 32-bit word; tracks dropped products and completed results.
module mpy_result_serializer
    import mpy_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    mpy_result_serializer_if.slave     bus,
    output logic [1:0]                 dbg_state_o
);

    logic [1:0]             state_q, state_d;
    logic [PROD_W-1:0]      hold_q, hold_d;
    logic [MPY_W-1:0]       word_q, word_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       done_q, done_d;

    logic [PROD_W-1:0]      head;
    logic [$clog2(DEPTH):0] occ;
    logic                   full;
    logic                   not_empty;
    logic                   pop;
    logic                   push;

    assign not_empty = (occ != '0);

    // A full FIFO still accepts a product when the FSM pops on the same edge.
    assign push  = bus.prod_valid && (!full || pop);
    assign ovf_d = ovf_q || (bus.prod_valid && full && !pop);

    mpy_prod_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK    (CLK),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (bus.prod_in),
        .head_o (head),
        .occ_o  (occ),
        .full_o (full)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        word_d  = word_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = done_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    state_d = ST_LO;
                    word_d  = head[MPY_W-1:0];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            ST_LO: begin
                if (bus.word_ready) begin
                    state_d = ST_HI;
                    word_d  = hold_q[PROD_W-1:MPY_W];
                    last_d  = 1'b1;
                end
            end
            ST_HI: begin
                if (bus.word_ready) begin
                    done_d = done_q + CNT_W'(1);
                    // Chain straight into the next product to sustain 2 cycles/result.
                    if (not_empty) begin
                        pop     = 1'b1;
                        hold_d  = head;
                        state_d = ST_LO;
                        word_d  = head[MPY_W-1:0];
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        word_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                word_d  = '0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.word_out     = word_q;
    assign bus.word_valid   = valid_q;
    assign bus.word_last    = last_q;
    assign bus.fifo_full    = full;
    assign bus.overflow     = ovf_q;
    assign bus.results_done = done_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mpy_result_serializer.sv
// Self-checking bench for mpy_result_serializer: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_mpy_result_serializer;
    import mpy_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    always #5 CLK = ~CLK;

    mpy_result_serializer_if #(.CNT_W(CNT_W)) bus ();

    mpy_result_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [MPY_W-1:0] exp_q[$];
    logic [MPY_W-1:0] got_q[$];

    // Reference model: products waiting, product being sent and which half.
    logic [PROD_W-1:0] m_fifo[$];
    logic [PROD_W-1:0] m_cur;
    int                m_phase;     // 0 nothing shown, 1 low half, 2 high half
    logic [CNT_W-1:0]  m_done;
    logic              m_ovf;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_fifo.delete();
        exp_q.delete();
        m_cur   = '0;
        m_phase = 0;
        m_done  = '0;
        m_ovf   = 1'b0;
    endtask

    function automatic logic [MPY_W-1:0] exp_word();
        case (m_phase)
            1:       return m_cur[31:0];
            2:       return m_cur[63:32];
            default: return '0;
        endcase
    endfunction

    // One clock edge of the serializer's documented behaviour.
    task automatic model_step();
        bit take = 1'b0;
        bit keep = 1'b0;
        case (m_phase)
            0: take = (m_fifo.size() > 0);
            1: if (bus.word_ready) m_phase = 2;
            default: begin
                if (bus.word_ready) begin
                    m_done = m_done + 1'b1;
                    if (m_fifo.size() > 0) take = 1'b1;
                    else m_phase = 0;
                end
            end
        endcase
        if (bus.prod_valid) begin
            if (m_fifo.size() < DEPTH || take) keep = 1'b1;
            else m_ovf = 1'b1;
        end
        if (take) begin
            m_cur   = m_fifo.pop_front();
            m_phase = 1;
            exp_q.push_back(m_cur[31:0]);
            exp_q.push_back(m_cur[63:32]);
        end
        if (keep) m_fifo.push_back(bus.prod_in);
    endtask

    // Monitor: transfers are read in the edge's active region (pre-update
    // values); the per-cycle output check runs 1 time unit later.
    always @(posedge CLK) begin
        if (reset) begin
            model_clear();
        end else begin
            if (bus.word_valid && bus.word_ready) begin
                got_q.push_back(bus.word_out);
                if (exp_q.size() == 0) check_val("sb_unexpected_word", bus.word_out, 64'hx);
                else check_val("sb_word", bus.word_out, exp_q.pop_front());
            end
            model_step();
        end
        #1;
        check_val("word_valid", bus.word_valid, m_phase != 0);
        check_val("word_out", bus.word_out, exp_word());
        check_val("word_last", bus.word_last, m_phase == 2);
        check_val("fifo_full", bus.fifo_full, m_fifo.size() == DEPTH);
        check_val("overflow", bus.overflow, m_ovf);
        check_val("results_done", bus.results_done, m_done);
        check_val("fsm_state", dbg_state, m_phase);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit pv, input logic [63:0] p, input bit rdy);
        @(negedge CLK);
        bus.prod_valid = pv;
        bus.prod_in    = p;
        bus.word_ready = rdy;
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 64'h0, rdy);
    endtask

    logic [63:0] prods[6];

    initial begin
        reset          = 1'b1;
        bus.prod_valid = 1'b0;
        bus.prod_in    = '0;
        bus.word_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge CLK);
        check_val("rst_word_valid", bus.word_valid, 1'b0);
        check_val("rst_results_done", bus.results_done, 0);
        reset = 1'b0;

        // Positive product 30*90
        got_q.delete();
        drive(1'b1, 64'h0000_0000_0000_0A8C, 1'b1);
        idle_cycles(5, 1'b1);
        check_val("pos_nwords", got_q.size(), 2);
        check_val("pos_lo", got_q[0], 32'h0000_0A8C);
        check_val("pos_hi", got_q[1], 32'h0000_0000);
        check_val("pos_done", bus.results_done, 1);

        // Negative product -2700 then square 8100, back to back
        got_q.delete();
        drive(1'b1, 64'hFFFF_FFFF_FFFF_F574, 1'b1);
        drive(1'b1, 64'h0000_0000_0000_1FA4, 1'b1);
        idle_cycles(6, 1'b1);
        check_val("neg_nwords", got_q.size(), 4);
        check_val("neg_lo", got_q[0], 32'hFFFF_F574);
        check_val("neg_hi", got_q[1], 32'hFFFF_FFFF);
        check_val("sq_lo", got_q[2], 32'h0000_1FA4);
        check_val("sq_hi", got_q[3], 32'h0000_0000);
        check_val("neg_done", bus.results_done, 3);

        // Backpressure on a pending low word
        drive(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
        idle_cycles(2, 1'b0);
        check_val("bp_lo_held", bus.word_out, 32'h9ABC_DEF0);
        idle_cycles(4, 1'b0);
        check_val("bp_lo_still", bus.word_out, 32'h9ABC_DEF0);
        drive(1'b0, 64'h0, 1'b1);
        drive(1'b0, 64'h0, 1'b0);
        check_val("bp_hi_next", bus.word_out, 32'h1234_5678);
        check_val("bp_hi_last", bus.word_last, 1'b1);
        idle_cycles(3, 1'b1);

        // Overflow: six products into hold + 4-entry FIFO with ready low
        for (int i = 0; i < 6; i++) prods[i] = {32'hA000_0000 + 32'(i), 32'h0000_0B00 + 32'(i)};
        for (int i = 0; i < 6; i++) drive(1'b1, prods[i], 1'b0);
        idle_cycles(1, 1'b0);
        check_val("ovf_full", bus.fifo_full, 1'b1);
        check_val("ovf_flag", bus.overflow, 1'b1);
        got_q.delete();
        idle_cycles(14, 1'b1);
        check_val("ovf_nwords", got_q.size(), 10);
        for (int i = 0; i < 5; i++) begin
            check_val("ovf_lo", got_q[2*i], prods[i][31:0]);
            check_val("ovf_hi", got_q[2*i+1], prods[i][63:32]);
        end
        check_val("ovf_done", bus.results_done, 9);
        check_val("ovf_sticky", bus.overflow, 1'b1);

        // Simultaneous push/pop while full, FSM in HI with ready high
        for (int i = 0; i < 5; i++) drive(1'b1, {32'hC000_0000, 32'(i)}, 1'b0);
        idle_cycles(1, 1'b0);
        check_val("sim_full_before", bus.fifo_full, 1'b1);
        drive(1'b0, 64'h0, 1'b1);
        drive(1'b1, 64'hC0DE_0000_0000_0055, 1'b1);
        drive(1'b0, 64'h0, 1'b0);
        check_val("sim_full_after", bus.fifo_full, 1'b1);
        check_val("sim_ovf", bus.overflow, 1'b1);
        got_q.delete();
        idle_cycles(14, 1'b1);
        check_val("sim_nwords", got_q.size(), 10);
        check_val("sim_last_lo", got_q[8], 32'h0000_0055);
        check_val("sim_done", bus.results_done, 15);

        // Reset while the high word is on the bus
        drive(1'b1, 64'h7777_8888_9999_AAAA, 1'b0);
        idle_cycles(2, 1'b0);
        drive(1'b0, 64'h0, 1'b1);
        drive(1'b0, 64'h0, 1'b0);
        check_val("prerst_last", bus.word_last, 1'b1);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_val("rst_async_valid", bus.word_valid, 1'b0);
        check_val("rst_async_done", bus.results_done, 0);
        check_val("rst_async_ovf", bus.overflow, 1'b0);
        @(negedge CLK);
        reset = 1'b0;
        got_q.delete();
        drive(1'b1, 64'h0000_0001_FFFF_FFFE, 1'b1);
        idle_cycles(5, 1'b1);
        check_val("postrst_nwords", got_q.size(), 2);
        check_val("postrst_lo", got_q[0], 32'hFFFF_FFFE);
        check_val("postrst_hi", got_q[1], 32'h0000_0001);
        check_val("postrst_done", bus.results_done, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
        end

        // Drain with a bounded wait
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && m_fifo.size() == 0 && m_phase == 0) break;
            drive(1'b0, 64'h0, 1'b1);
        end
        check_val("drain_exp_empty", exp_q.size(), 0);
        check_val("drain_idle", bus.word_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mpy_result_serializer.md
Name: mpy_result_serializer

Overview:
- Downstream stage of the 32x32 Booth multiplier.
- Captures each 64-bit signed product on the multiplier's one-cycle out_valid pulse and buffers it in a small FIFO.
- Emits each product as two 32-bit words, low then high, over a valid/ready handshake toward the 32-bit result bus.
- Keeps a sticky overflow flag and a count of completed results.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- CNT_W, 16, width of the completed-result counter

Ports:
- CLK  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- prod_in  input  64  product from multiplier (out)
- prod_valid  input  1  one-cycle strobe (multiplier out_valid)
- word_out  output  32  serialized word
- word_valid  output  1  word_out valid
- word_ready  input  1  consumer accepts word_out
- word_last  output  1  high while word_out carries the high half
- fifo_full  output  1  FIFO holds DEPTH entries
- overflow  output  1  sticky: a product was dropped
- results_done  output  CNT_W  count of products fully transmitted

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - FIFO is empty and its pointers are 0.
  - FSM is in IDLE.
  - word_out=0, word_valid=0, word_last=0, fifo_full=0, overflow=0, results_done=0.
  - Reset asserted mid-operation drops all buffered and in-flight data; nothing resumes.
- Push:
  - prod_in is written when prod_valid=1 at a rising edge, provided the FIFO is not full or a pop occurs on the same edge.
  - If full with no pop on that edge, the product is discarded and overflow is set. overflow clears only on reset.
- FIFO:
  - Circular buffer, read/write pointers of log2(DEPTH) bits.
  - Occupancy counter runs 0..DEPTH.
  - Pointers wrap modulo DEPTH.
  - fifo_full = (occupancy == DEPTH).
- FSM states: IDLE, LO, HI. Holding register hold[63:0].
  - IDLE: word_valid=0. If occupancy>0: hold<=head, pop, go to LO.
  - LO: word_valid=1, word_out=hold[31:0], word_last=0. On word_ready=1: go to HI.
  - HI: word_valid=1, word_out=hold[63:32], word_last=1.
    - On word_ready=1: increment results_done (wraps at 2^CNT_W).
    - If occupancy>0: hold<=head, pop, go to LO (back-to-back, no IDLE bubble). Else go to IDLE.
  - A push and a pop on the same edge leave occupancy unchanged.
  - A push into an empty FIFO is not visible to IDLE until the next edge.
- Latency:
  - Product captured at edge k with the FIFO empty and FSM in IDLE: word_valid rises after edge k+1 (low word).
  - The high word follows the first edge with word_ready=1.
  - Throughput is one product per 2 cycles with word_ready held high.
- Handshake:
  - word_out, word_last and word_valid are registered.
  - They hold stable while word_valid=1 and word_ready=0.
  - word_ready is ignored in IDLE.
- Data: no arithmetic on the product. The high word carries the sign bits unchanged.

Decomposition:
- Shared package/header (mpy_pkg): FSM state encodings (IDLE=2'd0, LO=2'd1, HI=2'd2), MPY_W=32, PROD_W=64.
- One sub-module: mpy_prod_fifo (parameterised DEPTH x 64 circular FIFO exposing push, pop, head, occupancy, full).
- FSM, counter and overflow logic stay in the top module.

Test Plan:
- Positive product: prod_in=30*90=64'h0000_0000_0000_0A8C pulsed, word_ready=1 -> words 32'h00000A8C (last=0) then 32'h00000000 (last=1); results_done=1.
- Negative product: prod_in=-2700=64'hFFFF_FFFF_FFFF_F574 -> words 32'hFFFFF574 then 32'hFFFFFFFF (last=1); square 8100=64'h1FA4 gives 32'h00001FA4, 32'h0.
- Backpressure: word_ready=0 for 5 cycles with a pending low word -> word_out/word_valid stable. Ready at cycle 6 -> high word the next cycle.
- Overflow: word_ready=0, pulse 6 distinct products (DEPTH=4) -> FSM holds #1, FIFO holds #2..#5, fifo_full=1, #6 dropped, overflow=1. Release ready -> exactly 10 words in order, results_done=5, overflow stays 1.
- Simultaneous push/pop: FIFO full, FSM in HI with ready=1 and a prod_valid on the same edge -> new product accepted, occupancy stays DEPTH, overflow unchanged.
- Reset mid-HI: assert reset during the high word -> word_valid=0 immediately (async), results_done=0. After release, a new product serializes correctly from its low word.
